// File: rtl/stein_lcm.sv
// stein_lcm: sequential LCM of two 7-bit magnitudes.
// Binary (Stein) GCD, then a restoring divide (A0 / g) and a shift-add multiply (q * B0).
module stein_lcm (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] res
);

  localparam int unsigned OP_W  = 7;
  localparam int unsigned RES_W = 16;
  localparam int unsigned K_W   = 3;
  localparam int unsigned CNT_W = 3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GCD  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Last DIV / MUL step index (7 steps each).
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(OP_W - 1);

  logic [2:0]       state_q, state_d;
  logic [OP_W-1:0]  a0_q, a0_d;
  logic [OP_W-1:0]  b0_q, b0_d;
  logic [OP_W-1:0]  x_q, x_d;
  logic [OP_W-1:0]  y_q, y_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [OP_W-1:0]  g_q, g_d;
  logic [OP_W-1:0]  rem_q, rem_d;
  logic [OP_W-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [OP_W:0]    div_trial;
  logic [OP_W-1:0]  a_mag, b_mag;

  // Sign bits are dropped; only the magnitudes take part.
  logic sign_unused;
  assign sign_unused = a[7] ^ b[7];
  assign a_mag = a[OP_W-1:0];
  assign b_mag = b[OP_W-1:0];

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a0_q    <= '0;
      b0_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      g_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a0_q    <= a0_d;
      b0_q    <= b0_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      g_q     <= g_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and datapath update for each phase.
  always_comb begin
    state_d   = state_q;
    a0_d      = a0_q;
    b0_d      = b0_q;
    x_d       = x_q;
    y_d       = y_q;
    k_d       = k_q;
    g_d       = g_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    res_d     = res_q;
    done_d    = 1'b0;
    div_trial = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a0_d  = a_mag;
          b0_d  = b_mag;
          x_d   = a_mag;
          y_d   = b_mag;
          k_d   = '0;
          rem_d = '0;
          cnt_d = '0;
          acc_d = '0;
          // Zero operand: skip straight to DONE, the cleared accumulator is the result.
          if (a_mag == '0 || b_mag == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_GCD;
          end
        end
      end

      S_GCD: begin
        if (x_q == '0 || y_q == '0) begin
          g_d     = OP_W'((x_q | y_q) << k_q);
          quo_d   = a0_q;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end else if (!x_q[0] && !y_q[0]) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + K_W'(1);
        end else if (!x_q[0]) begin
          x_d = x_q >> 1;
        end else if (!y_q[0]) begin
          y_d = y_q >> 1;
        end else if (x_q > y_q) begin
          x_d = (x_q - y_q) >> 1;
        end else begin
          x_d = (y_q - x_q) >> 1;
          y_d = x_q;
        end
      end

      // Dividend bits shift out of quo MSB-first; quotient bits shift in at the LSB.
      S_DIV: begin
        div_trial = {rem_q, quo_q[OP_W-1]};
        if (div_trial >= {1'b0, g_q}) begin
          rem_d = OP_W'(div_trial - {1'b0, g_q});
          quo_d = {quo_q[OP_W-2:0], 1'b1};
        end else begin
          rem_d = div_trial[OP_W-1:0];
          quo_d = {quo_q[OP_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        if (quo_q[cnt_q]) begin
          acc_d = acc_q + (RES_W'(b0_q) << cnt_q);
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        res_d   = acc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // busy tracks the registered state so it drops together with the DONE->IDLE transition.
  always_comb begin
    busy_d = (state_d != S_IDLE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;

endmodule

// File: tb/tb_stein_lcm.sv
// Scoreboard bench for stein_lcm: stimulus pushes expected result and completion cycle,
// a negedge monitor pops and checks on every done pulse and checks res holds otherwise.
module tb_stein_lcm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] res;

  typedef struct {
    int res;
    int at;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_res = 0;

  stein_lcm dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // lcm via Euclid; 0 if either magnitude is 0.
  function automatic int ref_lcm(input int x, input int y);
    int p, q, t;
    if (x == 0 || y == 0) return 0;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return (x / p) * y;
  endfunction

  // Cycles from acceptance to done: Stein step count N plus 16, or 1 for a zero operand.
  function automatic int ref_lat(input int x0, input int y0);
    int x, y, t, n;
    if (x0 == 0 || y0 == 0) return 1;
    x = x0;
    y = y0;
    n = 0;
    while (x != 0 && y != 0 && n < 64) begin
      if (x % 2 == 0 && y % 2 == 0) begin
        x = x / 2;
        y = y / 2;
      end else if (x % 2 == 0) begin
        x = x / 2;
      end else if (y % 2 == 0) begin
        y = y / 2;
      end else if (x > y) begin
        x = (x - y) / 2;
      end else begin
        t = x;
        x = (y - x) / 2;
        y = t;
      end
      n++;
    end
    return n + 16;
  endfunction

  task automatic push_exp(input logic [7:0] ia, input logic [7:0] ib, input int acc_cyc);
    exp_t e;
    e.res = ref_lcm(int'(ia[6:0]), int'(ib[6:0]));
    e.at  = acc_cyc + ref_lat(int'(ia[6:0]), int'(ib[6:0]));
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [7:0] ia, input logic [7:0] ib);
    @(posedge clk);
    #1;
    start = 1'b1;
    a = ia;
    b = ib;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(ia, ib, cyc);
    check("busy_after_accept", int'(busy), 1);
    wait_drain(40);
  endtask

  // Monitor: compare every done pulse against the scoreboard, and res stability otherwise.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      last_res = 0;
    end else if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: res=%0d with nothing pending", res);
      end else begin
        e = sb.pop_front();
        check("res", int'(res), e.res);
        check("done_cycle", cyc, e.at);
        check("busy_at_done", int'(busy), 0);
        last_res = e.res;
      end
    end else begin
      check("res_hold", int'(res), last_res);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] ra, rb;
    int acc_cyc;
    int lat2;

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset_res", int'(res), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed cases.
    run(8'd12, 8'd18);
    run(8'd7, 8'd7);
    run(8'd127, 8'd126);
    run(8'd0, 8'd5);
    run(8'd9, 8'd0);
    run(8'h8C, 8'h92);

    // Random operands, occasionally forcing a zero magnitude.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra[6:0] = '0;
      if ($urandom_range(0, 7) == 0) rb[6:0] = '0;
      run(ra, rb);
    end

    // start held high: operands latched only at acceptance, next run starts right after DONE.
    @(posedge clk);
    #1;
    start = 1'b1;
    a = 8'd12;
    b = 8'd18;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    check("held_busy", int'(busy), 1);
    push_exp(8'd12, 8'd18, acc_cyc);
    push_exp(8'd20, 8'd30, acc_cyc + 21);
    lat2 = ref_lat(20, 30);
    repeat (3) @(posedge clk);
    #1;
    a = 8'd20;
    b = 8'd30;
    repeat (21 + lat2 - 3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(80);

    // Asynchronous reset during MUL clears outputs before the next clock edge.
    @(posedge clk);
    #1;
    start = 1'b1;
    a = 8'd12;
    b = 8'd18;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(8'd12, 8'd18, cyc);
    repeat (15) @(posedge clk);
    #2;
    check("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("async_res", int'(res), 0);
    check("async_busy", int'(busy), 0);
    check("async_done", int'(done), 0);
    sb.delete();
    #4;
    reset = 1'b0;

    run(8'd4, 8'd6);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stein_lcm.md
# stein_lcm

Sequential least-common-multiple unit built on the binary (Stein) GCD iteration. It accepts two 8-bit operands on a start handshake and runs Stein steps to find gcd. It then computes lcm = (a / gcd) * b with a restoring divider and a shift-add multiplier. It returns a 16-bit result with a one-cycle done pulse. It is the consumer-side companion of the GCD datapath, turning a GCD into the multiple the downstream arithmetic needs.

## Interface
Parameters: none (widths fixed).
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk, accepted only in IDLE.
- a  input  8  operand A; bit 7 is a sign bit and is ignored, magnitude is a[6:0].
- b  input  8  operand B; bit 7 is ignored, magnitude is b[6:0].
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when res is updated.
- res  output  16  lcm(a[6:0], b[6:0]); holds its value until the next completion.

## Operation
- States: IDLE, GCD, DIV, MUL, DONE.
- **Reset (async):**
  - State goes to IDLE.
  - res=0, done=0, busy=0.
  - All internal registers are cleared.
- **IDLE, start=1:**
  - Latch A0=a[6:0], B0=b[6:0] and working copies x=A0, y=B0; set shift count k=0.
  - If A0==0 or B0==0, go to DONE with result 0.
  - Otherwise go to GCD.
  - start in any other state is ignored; no queuing.
- **GCD:** one Stein step per cycle, evaluated in this priority order.
  - x==0 or y==0: g = (nonzero of x,y) << k; go to DIV.
  - x, y both even: x>>=1, y>>=1, k+=1.
  - x even only: x>>=1.
  - y even only: y>>=1.
  - Both odd, x>y: x=(x-y)>>1, y unchanged.
  - Both odd, x<=y: x=(y-x)>>1, y=x(old).
- **Width rules:**
  - x, y are 7 bits; k is 3 bits; g fits in 7 bits.
  - Subtraction is unsigned and never underflows because of the ordering above.
- **DIV:** restoring division q = A0 / g.
  - 7 cycles, one quotient bit per cycle, MSB first.
  - 7-bit partial remainder; the remainder is always 0 at the end.
  - q is 7 bits.
- **MUL:** shift-add product p = q * B0.
  - 7 cycles, LSB of q first; the accumulator is 16 bits.
  - Maximum result 127*126 = 16002, so there is no overflow.
- **DONE:**
  - res <= result (p, or 0 on the zero-operand path).
  - done=1 for this cycle only.
  - Next state IDLE unconditionally.

## Timing
- Cycle 0 is the edge where start is accepted. Let N = number of Stein steps before an operand reaches 0; N ≤ 14.
- Schedule:
  - GCD occupies cycles 1..N+1.
  - DIV occupies cycles N+2..N+8.
  - MUL occupies cycles N+9..N+15.
  - DONE is cycle N+16.
- done and the new res become visible at cycle N+16; latency is N+16 cycles and at most 30.
- Zero-operand path: DONE at cycle 1, res=0, latency 1.
- busy rises the cycle after acceptance and falls with the DONE→IDLE transition (cycle N+17).
- A new start is accepted at the earliest in cycle N+17 (back-to-back after DONE).
- res does not change between completions, including while a new computation is in progress.
- Reset mid-operation (any state): outputs clear immediately, without waiting for clk; the partial computation is discarded.
- reset and start together: reset wins.

## Test plan
- a=12, b=18, pulse start → N=4, g=6, res=36, done high exactly 20 cycles after acceptance, busy low the following cycle.
- a=7, b=7 → N=1, res=7, done at cycle 17; then a=127, b=126 → res=16002 (gcd 1, largest result).
- a=0, b=5 and a=9, b=0 → res=0, done at cycle 1, GCD state never entered.
- a=8'h8C, b=8'h92 (sign bits set) → magnitudes 12 and 18, res=36.
- start held high continuously with a=12, b=18; change a and b mid-run → operands latched at acceptance only, res=36, the next computation begins the cycle after DONE.
- Assert reset asynchronously during MUL of a 12/18 run → res=0, busy=0, done=0 before the next clk edge; a following run of a=4, b=6 → res=12.
